// File: rtl/mmio_hub_if.sv
// Core-side MMIO bus for mmio_hub: one-cycle rd/wr pulses in, combinational window select,
// registered read data and a one-cycle ready out. No stall path; one access per cycle.
interface mmio_hub_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic        io_sel;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, wdata, rd_en, wr_en, input io_sel, rdata, ready);
  modport slave  (input addr, wdata, rd_en, wr_en, output io_sel, rdata, ready);
endinterface

// File: rtl/mmio_hub.sv
// LED/switch MMIO hub: ready and rdata one cycle after a request, never stalls, one access/cycle.
// Define MMIO_BLINK_EN to build the blink mask register and its BLINK_DIV phase prescaler.
module mmio_hub #(
  parameter int NUM_LED_CH      = 3,
  parameter int NUM_SW_CH       = 3,
  parameter int CH_W            = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 2500000
) (
  input  logic                        clock,
  input  logic                        rst,
  mmio_hub_if.slave                   bus,
  input  logic [NUM_SW_CH*CH_W-1:0]   sw_i,
  output logic [NUM_LED_CH*CH_W-1:0]  led_o
);
  localparam int               LED_W   = NUM_LED_CH * CH_W;
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [26:0]      IO_BASE = 27'h7FFFFE3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] idx;
  logic       rd_take;
  logic       wr_take;

  logic [CH_W-1:0]      led_q    [NUM_LED_CH];
  logic [CH_W-1:0]      led_d    [NUM_LED_CH];
  logic [CH_W-1:0]      sync1_q  [NUM_SW_CH];
  logic [CH_W-1:0]      sync2_q  [NUM_SW_CH];
  logic [CH_W-1:0]      stable_q [NUM_SW_CH];
  logic [CH_W-1:0]      stable_d [NUM_SW_CH];
  logic [CNT_W-1:0]     cnt_q    [NUM_SW_CH];
  logic [CNT_W-1:0]     cnt_d    [NUM_SW_CH];
  logic [NUM_SW_CH-1:0] status_q, status_d, chg;
  logic [31:0]          rdata_q, rdata_d, rd_val;
  logic                 ready_q, ready_d;
  logic [LED_W-1:0]     led_flat;
  logic                 unused_ok;

  assign bus.io_sel = (bus.addr[31:5] == IO_BASE);
  assign idx        = bus.addr[4:2];
  assign wr_take    = bus.io_sel & bus.wr_en;
  // A simultaneous write wins; the read is dropped and does not clear status.
  assign rd_take    = bus.io_sel & bus.rd_en & ~bus.wr_en;

  assign bus.rdata  = rdata_q;
  assign bus.ready  = ready_q;
  assign unused_ok  = ^{bus.wdata, bus.addr[1:0], 32'(BLINK_DIV)};

  for (genvar g = 0; g < NUM_LED_CH; g++) begin : g_led_flat
    assign led_flat[g*CH_W +: CH_W] = led_q[g];
  end

`ifdef MMIO_BLINK_EN
  localparam int PRE_W = $clog2(BLINK_DIV + 1);

  logic [LED_W-1:0] mask_q, mask_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             phase_q, phase_d;

  always_comb begin
    mask_d  = (wr_take && idx == 3'd3) ? bus.wdata[LED_W-1:0] : mask_q;
    pre_d   = pre_q + PRE_W'(1);
    phase_d = phase_q;
    if (pre_q == PRE_W'(BLINK_DIV - 1)) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      mask_q  <= '0;
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  assign led_o = led_flat & ~(mask_q & {LED_W{phase_q}});
`else
  assign led_o = led_flat;
`endif

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_LED_CH; i++) begin
      if (idx == 3'(i)) rd_val[CH_W-1:0] = led_q[i];
    end
    for (int i = 0; i < NUM_SW_CH; i++) begin
      if (idx == 3'(4 + i)) rd_val[CH_W-1:0] = stable_q[i];
    end
`ifdef MMIO_BLINK_EN
    if (idx == 3'd3) rd_val[LED_W-1:0] = mask_q;
`endif
    if (idx == 3'd7) rd_val[NUM_SW_CH-1:0] = status_q;
  end

  always_comb begin
    ready_d = bus.io_sel & (bus.rd_en | bus.wr_en);
    rdata_d = rd_take ? rd_val : '0;
    for (int i = 0; i < NUM_LED_CH; i++) begin
      led_d[i] = (wr_take && idx == 3'(i)) ? bus.wdata[CH_W-1:0] : led_q[i];
    end
  end

  // Counter runs only while the synchronized value disagrees with the stable one.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_SW_CH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] + CNT_ONE == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          chg[i]      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    status_d = (status_q & ~{NUM_SW_CH{rd_take && idx == 3'd7}}) | chg;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      status_q <= '0;
      for (int i = 0; i < NUM_LED_CH; i++) led_q[i] <= '0;
      for (int i = 0; i < NUM_SW_CH; i++) begin
        sync1_q[i]  <= '0;
        sync2_q[i]  <= '0;
        stable_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      status_q <= status_d;
      for (int i = 0; i < NUM_LED_CH; i++) led_q[i] <= led_d[i];
      for (int i = 0; i < NUM_SW_CH; i++) begin
        sync1_q[i]  <= sw_i[i*CH_W +: CH_W];
        sync2_q[i]  <= sync1_q[i];
        stable_q[i] <= stable_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end
endmodule
